stack_ctrl: RTL

//  Request/response front-end for the shift-register Stack (push/pop/data_IN/data_OUT).

---
 rtl/stack_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
// Request/response front-end for a shift-register Stack. Commands (push, pop,
// peek, illegal) arrive on a valid/ready handshake. The controller tracks
// occupancy, drives single-cycle push/pop strobes to the Stack, and returns
// popped/peeked data (or an error) on a second valid/ready handshake.
// Overflow is recorded in a sticky flag. Underflow and illegal ops complete
// with an error response.
//
// Optional feature macro: STACK_CTRL_PEEK_EN
//   defined   : op 2'b10 is peek (read top without popping).
//   undefined : op 2'b10 is illegal, like 2'b11.
//
// Ports
//   clk        in   Clock, rising edge.
//   rst        in   Asynchronous reset, active-low.
//   in_valid   in   Command valid.
//   in_ready   out  Command accepted when in_valid & in_ready.
//   in_op      in   00 push, 01 pop, 10 peek/illegal, 11 illegal.
//   in_data    in   Push data.
//   out_valid  out  Response valid (pop/peek/error only).
//   out_ready  in   Response consumed when out_valid & out_ready.
//   out_data   out  Popped/peeked word, 0 on error.
//   out_err    out  Response is an error.
//   stk_push   out  Stack push strobe (one cycle).
//   stk_pop    out  Stack pop strobe (one cycle).
//   stk_clr    out  Stack clear, equals ~rst.
//   stk_wdata  out  Stack data_IN, registered command data.
//   stk_rdata  in   Stack data_OUT (top of stack).
//   depth      out  Occupancy 0..LENGTH.
//   full       out  depth == LENGTH.
//   empty      out  depth == 0.
//   ovf        out  Sticky: push attempted while full.
// ---------------------------------------------------------------------------
module stack_ctrl #(
  parameter int LENGTH     = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic                  stk_clr,
  output logic [DATA_WIDTH-1:0] stk_wdata,
  input  logic [DATA_WIDTH-1:0] stk_rdata,
  output logic [CNT_WIDTH-1:0]  depth,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;

  localparam logic [CNT_WIDTH-1:0] LEN_C = CNT_WIDTH'(LENGTH);
  localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

  state_t                  state_q;
  logic [1:0]              op_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    out_err_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    stk_push_q;
  logic                    stk_pop_q;
  logic [DATA_WIDTH-1:0]   stk_wdata_q;
  logic [CNT_WIDTH-1:0]    depth_q;
  logic                    ovf_q;

  logic full_d;
  logic empty_d;
  logic accept_d;

  assign full_d   = (depth_q == LEN_C);
  assign empty_d  = (depth_q == '0);
  assign accept_d = in_valid & in_ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= OP_PUSH;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
      stk_wdata_q <= '0;
      depth_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            op_q        <= in_op;
            stk_wdata_q <= in_data;
            in_ready_q  <= 1'b0;
            state_q     <= EXEC;
            // The strobe must be live during EXEC, so the legality decision
            // is made here; depth cannot change between accept and EXEC.
            stk_push_q  <= (in_op == OP_PUSH) && !full_d;
            stk_pop_q   <= (in_op == OP_POP)  && !empty_d;
          end else begin
            // First cycle after reset release raises in_ready here.
            in_ready_q <= 1'b1;
          end
        end

        EXEC: begin
          stk_push_q <= 1'b0;
          stk_pop_q  <= 1'b0;
          case (op_q)
            OP_PUSH: begin
              if (stk_push_q) depth_q <= depth_q + ONE_C;
              else            ovf_q   <= 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= IDLE;
            end
            OP_POP: begin
              // stk_rdata is still the old top until this edge shifts the Stack.
              if (stk_pop_q) begin
                out_data_q <= stk_rdata;
                out_err_q  <= 1'b0;
                depth_q    <= depth_q - ONE_C;
              end else begin
                out_data_q <= '0;
                out_err_q  <= 1'b1;
              end
              out_valid_q <= 1'b1;
              state_q     <= RESP;
            end
`ifdef STACK_CTRL_PEEK_EN
            OP_PEEK: begin
              out_data_q  <= empty_d ? '0 : stk_rdata;
              out_err_q   <= empty_d;
              out_valid_q <= 1'b1;
              state_q     <= RESP;
            end
`endif
            default: begin
              out_data_q  <= '0;
              out_err_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          endcase
        end

        RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign stk_push  = stk_push_q;
  assign stk_pop   = stk_pop_q;
  assign stk_clr   = ~rst;
  assign stk_wdata = stk_wdata_q;
  assign depth     = depth_q;
  assign full      = full_d;
  assign empty     = empty_d;
  assign ovf       = ovf_q;

endmodule
